branch_ctrl: RTL
================

# branch_ctrl

- Sequences control-flow redirection for the five-stage core.
- Tracks a conditional branch from ID into EX, resolves it against the ALU zero flag one cycle later, and drives the PC-select mux.
- Generates pipeline flush strobes under a predict-not-taken policy.
- Sits between the decoder, the ALU and the IF/ID and ID/EX pipeline registers; it replaces ad-hoc pc_src gating with an explicit state machine.

## Interface

Parameters:
- CNT_W, 32, width of each statistics counter (used only with BRANCH_STATS_EN).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline freeze (load-use hazard); holds FSM and counters.
- branch  in  1  ID stage holds a conditional branch.
- jump  in  1  ID stage holds JAL/JALR.
- zero  in  1  ALU zero flag for the instruction currently in EX.
- pc_src  out  1  1 selects branch/jump target, 0 selects PC+4.
- flush_if_id  out  1  clear IF/ID register at next edge.
- flush_id_ex  out  1  clear ID/EX register at next edge.
- branch_pending  out  1  registered; a branch is in EX awaiting resolution.
- taken_cnt, jump_cnt, branch_cnt  out  CNT_W each  statistics counters (BRANCH_STATS_EN only).

## Operation

- States: IDLE, BR_EX.
- IDLE:
  - jump=1: pc_src=1 and flush_if_id=1 combinationally; remain IDLE.
  - Jump has priority: if jump and branch are both 1, branch is ignored.
  - branch=1, jump=0: next state BR_EX; pc_src=0; no flush.
  - Otherwise all outputs 0.
- BR_EX (branch in EX; branch_pending=1):
  - zero=1 (taken): pc_src=1, flush_if_id=1, flush_id_ex=1; next IDLE. branch and jump in this cycle belong to a wrong-path instruction and are ignored.
  - zero=0, jump=1: pc_src=1, flush_if_id=1; next IDLE.
  - zero=0, branch=1, jump=0: back-to-back branch; remain BR_EX.
  - zero=0, neither: next IDLE, no outputs asserted.
- stall=1:
  - State and counters hold.
  - pc_src, flush_if_id and flush_id_ex are forced 0.
  - The decision is re-evaluated on the first cycle with stall=0.
- rst=1:
  - State goes to IDLE and counters clear at the edge.
  - While rst is high, all combinational outputs are forced 0, including mid-resolution (a pending branch is dropped).
  - After reset: branch_pending=0, pc_src=0, flush_*=0, counters 0.

## Timing

- pc_src and flush_* are combinational from state, zero, branch, jump and stall, with zero added cycles. They must settle before the PC/pipeline-register edge.
- Branch penalty:
  - Taken branch: 2 cycles (IF/ID and ID/EX flushed).
  - Not-taken branch: 0 cycles.
  - Jump: 1 cycle.
- branch_pending rises one edge after branch is sampled in IDLE. It falls on the edge that resolves the branch.
- Counters update on the same edge as the state transition. They wrap modulo 2^CNT_W, with no saturation.

## Configuration

- BRANCH_STATS_EN defined:
  - branch_cnt increments once per branch accepted (IDLE→BR_EX, or BR_EX→BR_EX).
  - taken_cnt increments per taken resolution.
  - jump_cnt increments per accepted jump.
  - Ignored (wrong-path) requests are not counted.
- Not defined:
  - Counter registers are not instantiated; the three count ports are tied to 0.
  - Control behaviour is identical in both builds.

## Test plan

- Reset: hold rst 3 cycles with branch=1, zero=1 → pc_src=0, flush_*=0, branch_pending=0 throughout and after release; counters 0.
- Taken branch: branch=1 for 1 cycle, next cycle zero=1 → that cycle pc_src=1, flush_if_id=1, flush_id_ex=1; following cycle branch_pending=0; taken_cnt=1, branch_cnt=1.
- Not-taken back-to-back: branch=1 for 3 consecutive cycles, zero=0 → branch_pending high for 3 cycles, no flush ever; branch_cnt=3, taken_cnt=0.
- Jump/branch collision: in IDLE, jump=1 and branch=1 → pc_src=1, flush_if_id=1, flush_id_ex=0; state stays IDLE; jump_cnt=1, branch_cnt=0.
- Wrong-path suppression: branch in BR_EX with zero=1 and jump=1 in the same cycle → single redirect with both flushes; jump_cnt unchanged.
- Stall mid-resolution: enter BR_EX, hold stall=1 for 2 cycles with zero=1 → pc_src=0 during stall, branch_pending stays 1; first unstalled cycle with zero=1 → pc_src=1 and both flushes.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: predict-not-taken branch/jump redirect FSM with flush strobes; optional BRANCH_STATS_EN counters
module branch_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  output logic             pc_src,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             branch_pending,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [CNT_W-1:0] branch_cnt
);
  typedef enum logic {IDLE, BR_EX} state_t;
  state_t state;
  logic active, taken, jmp, br_acc;
  always_comb begin
    active = !rst && !stall;
    taken  = active && state == BR_EX && zero;
    // a taken branch squashes whatever sits in ID, so its requests are wrong-path
    jmp    = active && jump && !taken;
    br_acc = active && branch && !jump && !taken;
    pc_src      = taken || jmp;
    flush_if_id = taken || jmp;
    flush_id_ex = taken;
  end
  assign branch_pending = state == BR_EX;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (!stall) state <= br_acc ? BR_EX : IDLE;
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt  <= '0;
      jump_cnt   <= '0;
      branch_cnt <= '0;
    end else begin
      taken_cnt  <= taken_cnt + CNT_W'(taken);
      jump_cnt   <= jump_cnt + CNT_W'(jmp);
      branch_cnt <= branch_cnt + CNT_W'(br_acc);
    end
  end
`else
  assign taken_cnt  = '0;
  assign jump_cnt   = '0;
  assign branch_cnt = '0;
`endif
endmodule
